// File: rtl/picomips_sw_input_ctrl.sv
// Debounced push-button capture of the SW word into a first-word-fall-through FIFO for the picoMIPS core.
// Optional auto-repeat while the button is held: define PICOMIPS_AUTO_REPEAT_EN.
module picomips_sw_input_ctrl #(
  parameter int DATA_W          = 8,
  parameter int DEPTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 256
) (
  input  logic                       fastclk,
  input  logic                       reset,
  input  logic                       btn,
  input  logic [DATA_W-1:0]          SW,
  input  logic                       rd_en,
  input  logic                       ovf_clr,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       branch_status,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    PRESSED   = 2'd2,
    DEB_REL   = 2'd3
  } state_t;

  logic              btn_meta_reg;
  logic              sbtn_reg;
  logic [DATA_W-1:0] sw_meta_reg;
  logic [DATA_W-1:0] sw_sync_reg;

  state_t            state_reg, state_next;
  logic [DEB_W-1:0]  deb_cnt_reg, deb_cnt_next;
  logic              push;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg, head_next_ptr;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [DATA_W-1:0] rd_data_reg;
  logic              branch_reg;
  logic              overflow_reg;
  logic              pop, full, do_write, lost;

`ifdef PICOMIPS_AUTO_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0]  rpt_cnt_reg, rpt_cnt_next;
`endif

  always_ff @(posedge fastclk) begin
    if (!reset) begin
      btn_meta_reg <= 1'b0;
      sbtn_reg     <= 1'b0;
      sw_meta_reg  <= '0;
      sw_sync_reg  <= '0;
    end else begin
      btn_meta_reg <= btn;
      sbtn_reg     <= btn_meta_reg;
      sw_meta_reg  <= SW;
      sw_sync_reg  <= sw_meta_reg;
    end
  end

  always_ff @(posedge fastclk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      deb_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      deb_cnt_reg <= deb_cnt_next;
    end
  end

`ifdef PICOMIPS_AUTO_REPEAT_EN
  always_ff @(posedge fastclk) begin
    if (!reset) rpt_cnt_reg <= '0;
    else        rpt_cnt_reg <= rpt_cnt_next;
  end
`endif

  // One push per accepted press: only the DEB_PRESS -> PRESSED transition (or a repeat tick) pushes.
  always_comb begin
    state_next   = state_reg;
    deb_cnt_next = deb_cnt_reg;
    push         = 1'b0;
`ifdef PICOMIPS_AUTO_REPEAT_EN
    rpt_cnt_next = rpt_cnt_reg;
`endif
    unique case (state_reg)
      IDLE: begin
        if (sbtn_reg) begin
          state_next   = DEB_PRESS;
          deb_cnt_next = DEB_W'(1);
        end
      end
      DEB_PRESS: begin
        if (!sbtn_reg) begin
          state_next = IDLE;
        end else if (deb_cnt_reg == DEB_LAST) begin
          state_next   = PRESSED;
          deb_cnt_next = '0;
          push         = 1'b1;
`ifdef PICOMIPS_AUTO_REPEAT_EN
          rpt_cnt_next = '0;
`endif
        end else begin
          deb_cnt_next = deb_cnt_reg + 1'b1;
        end
      end
      PRESSED: begin
        if (!sbtn_reg) begin
          state_next   = DEB_REL;
          deb_cnt_next = DEB_W'(1);
        end
`ifdef PICOMIPS_AUTO_REPEAT_EN
        else if (rpt_cnt_reg == RPT_LAST) begin
          push         = 1'b1;
          rpt_cnt_next = '0;
        end else begin
          rpt_cnt_next = rpt_cnt_reg + 1'b1;
        end
`endif
      end
      DEB_REL: begin
        if (sbtn_reg) begin
          state_next = PRESSED;
`ifdef PICOMIPS_AUTO_REPEAT_EN
          rpt_cnt_next = '0;
`endif
        end else if (deb_cnt_reg == DEB_LAST) begin
          state_next   = IDLE;
          deb_cnt_next = '0;
        end else begin
          deb_cnt_next = deb_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next   = IDLE;
        deb_cnt_next = '0;
      end
    endcase
  end

  // A pop frees a slot on the same edge, so push+pop on a full FIFO is not an overflow.
  always_comb begin
    pop           = rd_en && (count_reg != '0);
    full          = (count_reg == FULL_COUNT);
    do_write      = push && (!full || pop);
    lost          = push && full && !pop;
    head_next_ptr = rd_ptr_reg + 1'b1;
    count_next    = count_reg;
    unique case ({do_write, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge fastclk) begin
    if (reset && do_write) mem[wr_ptr_reg] <= sw_sync_reg;
  end

  always_ff @(posedge fastclk) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      rd_data_reg  <= '0;
      branch_reg   <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (do_write) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)      rd_ptr_reg <= head_next_ptr;
      count_reg  <= count_next;
      branch_reg <= (count_next != '0);
      // Registered head: next entry on a pop, bypass the incoming word when it becomes the head.
      if (pop) begin
        if (count_reg != CNT_W'(1)) rd_data_reg <= mem[head_next_ptr];
        else if (do_write)          rd_data_reg <= sw_sync_reg;
      end else if (do_write && (count_reg == '0)) begin
        rd_data_reg <= sw_sync_reg;
      end
      if (lost)         overflow_reg <= 1'b1;
      else if (ovf_clr) overflow_reg <= 1'b0;
    end
  end

  assign rd_data       = rd_data_reg;
  assign branch_status = branch_reg;
  assign count         = count_reg;
  assign overflow      = overflow_reg;

endmodule

// File: tb/tb_picomips_sw_input_ctrl.sv
// Bench for picomips_sw_input_ctrl: vector table of presses plus hand sequences, FIFO words checked via a queue.
module tb_picomips_sw_input_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int DEB   = 4;
  localparam int RPT   = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          fastclk = 1'b0;
  logic          reset   = 1'b0;
  logic          btn     = 1'b0;
  logic [DW-1:0] SW      = '0;
  logic          rd_en   = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [DW-1:0] rd_data;
  logic          branch_status;
  logic [CW-1:0] count;
  logic          overflow;

  picomips_sw_input_ctrl #(
    .DATA_W(DW), .DEPTH(DEPTH), .DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(RPT)
  ) dut (
    .fastclk(fastclk), .reset(reset), .btn(btn), .SW(SW), .rd_en(rd_en), .ovf_clr(ovf_clr),
    .rd_data(rd_data), .branch_status(branch_status), .count(count), .overflow(overflow)
  );

  always #5 fastclk = ~fastclk;

  typedef struct {
    logic [7:0] sw;
    int         hold;
    bit         pop_at_push;
    bit         clr_at_push;
    int         exp_count;
    bit         exp_ovf;
    bit         drain;
  } vec_t;

  vec_t          tbl [13];
  logic [DW-1:0] exp_q [$];
  bit            movf;
  int            n_vec = 0;
  int            n_err = 0;
`ifdef PICOMIPS_AUTO_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  task automatic tick();
    @(posedge fastclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_one();
    logic [DW-1:0] w;
    w = exp_q.pop_front();
    check("pop_bs", 32'(branch_status), 32'd1);
    check("pop_data", 32'(rd_data), 32'(w));
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("pop_count", 32'(count), 32'(exp_q.size()));
    check("pop_bs_after", 32'(branch_status), 32'(exp_q.size() != 0));
    $display("pop  data=%02h count=%0d", w, count);
  endtask

  task automatic drain();
    while (exp_q.size() != 0) pop_one();
    if (movf) begin
      check("ovf_before_clr", 32'(overflow), 32'd1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      movf = 1'b0;
      check("ovf_after_clr", 32'(overflow), 32'd0);
      $display("clr  overflow=%0b", overflow);
    end
  endtask

  // btn high for 'hold' edges; the push edge is tick DEB+2 counted from the first high edge.
  task automatic press(input logic [7:0] w, input int hold, input bit pop_at_push, input bit clr_at_push);
    bit accepted;
    accepted = (hold >= DEB);
    SW = w;
    for (int i = 1; i <= hold + DEB + 6; i++) begin
      btn = (i <= hold);
      if (accepted && i == DEB + 2) begin
        if (pop_at_push) begin
          check("pp_data", 32'(rd_data), 32'(exp_q[0]));
          void'(exp_q.pop_front());
          rd_en = 1'b1;
        end
        if (clr_at_push) ovf_clr = 1'b1;
      end
      tick();
      rd_en = 1'b0;
      ovf_clr = 1'b0;
      if (accepted && i == DEB + 1)
        check("pre_push_count", 32'(count), 32'(exp_q.size()));
      if (accepted && i == DEB + 2) begin
        if (clr_at_push) movf = 1'b0;
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
        else movf = 1'b1;
        check("push_count", 32'(count), 32'(exp_q.size()));
      end
    end
    btn = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{8'hAA, 2, 0, 0, 0, 0, 0};
    tbl[1]  = '{8'hAB, 3, 0, 0, 0, 0, 0};
    tbl[2]  = '{8'h01, 8, 0, 0, 1, 0, 0};
    tbl[3]  = '{8'h02, 8, 0, 0, 2, 0, 0};
    tbl[4]  = '{8'h03, 8, 0, 0, 3, 0, 0};
    tbl[5]  = '{8'h04, 4, 0, 0, 4, 0, 0};
    tbl[6]  = '{8'h05, 8, 0, 0, 4, 1, 1};
    tbl[7]  = '{8'h11, 8, 0, 0, 1, 0, 0};
    tbl[8]  = '{8'h12, 8, 0, 0, 2, 0, 0};
    tbl[9]  = '{8'h13, 8, 0, 0, 3, 0, 0};
    tbl[10] = '{8'h14, 8, 0, 0, 4, 0, 0};
    tbl[11] = '{8'h15, 8, 1, 0, 4, 0, 0};
    tbl[12] = '{8'h16, 8, 0, 1, 4, 1, 1};
    movf = 1'b0;

    // Reset held with the button pressed and SW all ones.
    reset = 1'b0; btn = 1'b1; SW = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_bs", 32'(branch_status), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_data", 32'(rd_data), 32'd0);
    end
    $display("rst  count=%0d bs=%0b", count, branch_status);
    btn = 1'b0; reset = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // Single long press: exact latency, and no second push unless auto-repeat.
    SW = 8'h58;
    for (int i = 1; i <= 18 + DEB + 6; i++) begin
      btn = (i <= 18);
      tick();
      if (i == 5) check("lat_bs_early", 32'(branch_status), 32'd0);
      if (i == 6) begin
        check("lat_bs", 32'(branch_status), 32'd1);
        check("lat_count", 32'(count), 32'd1);
        check("lat_data", 32'(rd_data), 32'h58);
      end
      if (i == 14) check("repeat_count", 32'(count), REP ? 32'd2 : 32'd1);
    end
    btn = 1'b0;
    exp_q.push_back(8'h58);
    if (REP) exp_q.push_back(8'h58);
    check("hold_final_count", 32'(count), 32'(exp_q.size()));
    $display("hold sw=58 count=%0d", count);
    drain();

    // Table: glitches, fill/overflow, push+pop when full, clear racing an overflow.
    for (int v = 0; v < 13; v++) begin
      press(tbl[v].sw, tbl[v].hold, tbl[v].pop_at_push, tbl[v].clr_at_push);
      check("vec_count", 32'(count), 32'(tbl[v].exp_count));
      check("vec_ovf", 32'(overflow), 32'(tbl[v].exp_ovf));
      check("vec_bs", 32'(branch_status), 32'(tbl[v].exp_count != 0));
      $display("vec %0d sw=%02h hold=%0d count=%0d ovf=%0b", v, tbl[v].sw, tbl[v].hold, count, overflow);
      if (tbl[v].drain) drain();
    end

    // Reset in the middle of a debounce with a word already queued.
    press(8'h66, 8, 0, 0);
    SW = 8'h77; btn = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1; btn = 1'b0;
    exp_q.delete();
    movf = 1'b0;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_data", 32'(rd_data), 32'd0);
    for (int i = 0; i < DEB + 6; i++) tick();
    check("mid_rst_nopush", 32'(count), 32'd0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("empty_pop_count", 32'(count), 32'd0);
    check("empty_pop_bs", 32'(branch_status), 32'd0);
    check("empty_pop_data", 32'(rd_data), 32'd0);
    $display("mrst count=%0d bs=%0b", count, branch_status);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
